// File: rtl/irq_ctrl_pkg.sv
// irq_ctrl_pkg: shared definitions for the interrupt controller.
//   state_t       - FSM state encoding; the code is readable through the STATE register
//   *_OFF         - register offsets relative to BASE_ADDR
//   VEC_VALID_BIT - position of the valid flag inside the VECTOR register
package irq_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAISE = 2'd1,
    ST_ACK   = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  localparam logic [1:0] MASK_OFF  = 2'd0;
  localparam logic [1:0] PEND_OFF  = 2'd1;
  localparam logic [1:0] VEC_OFF   = 2'd2;
  localparam logic [1:0] STATE_OFF = 2'd3;

  localparam int VEC_VALID_BIT = 7;

endpackage

// File: rtl/irq_priority_sel.sv
// irq_priority_sel: combinational winner search over the request vector.
//   req   in  NUM_SRC  masked request vector
//   base  in  3        index where the search starts; wraps modulo NUM_SRC
//   found out 1        at least one request is set
//   idx   out 3        first set index at or after base (circularly)
module irq_priority_sel #(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [2:0]         base,
  output logic               found,
  output logic [2:0]         idx
);

  // Widened copy so a 3-bit index always fits, whatever NUM_SRC is.
  logic [7:0] req8;
  assign req8 = 8'(req);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(base) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!found && req8[j[2:0]]) begin
        found = 1'b1;
        idx   = j[2:0];
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller: shares one CPU interrupt request/ack pair among NUM_SRC sources.
//   CLK, RESET     clock, synchronous active-high reset
//   BUS_DATA       inout 8, driven only while a read of this block is in progress
//   BUS_ADDR/BUS_WE bus address and write enable; block spans BASE_ADDR..BASE_ADDR+3
//   SRC_RAISE      level requests; SRC_ACK one-cycle ack pulse to the granted source
//   CPU_INT_RAISE / CPU_INT_ACK  processor interrupt handshake
// Registers: +0 MASK (RW), +1 PENDING (RO), +2 VECTOR {valid,0000,idx}, +3 STATE (RO).
// Optional macro IRQ_CTRL_ROUND_ROBIN_EN: rotating priority starting after the
// last acknowledged source; without it the lowest requesting index wins.
module irq_controller
  import irq_ctrl_pkg::*;
#(
  parameter int         NUM_SRC   = 4,
  parameter logic [7:0] BASE_ADDR = 8'hE0
) (
  input  logic               CLK,
  input  logic               RESET,
  inout  wire  [7:0]         BUS_DATA,
  input  logic [7:0]         BUS_ADDR,
  input  logic               BUS_WE,
  input  logic [NUM_SRC-1:0] SRC_RAISE,
  output logic [NUM_SRC-1:0] SRC_ACK,
  output logic               CPU_INT_RAISE,
  input  logic               CPU_INT_ACK
);

  state_t             state;
  logic [NUM_SRC-1:0] mask;
  logic               vec_valid;
  logic [2:0]         vec_idx;
  logic [7:0]         rd_data, rd_mux, vec_rd;
  logic               drv_en;

  // Address decode by offset so the range test cannot overflow.
  logic [7:0] off;
  logic       hit, bus_wr;
  logic [1:0] roff;
  assign off    = BUS_ADDR - BASE_ADDR;
  assign hit    = (off < 8'd4);
  assign roff   = off[1:0];
  assign bus_wr = BUS_WE && hit;

  logic [NUM_SRC-1:0] req;
  logic [7:0]         req8, ack_oh;
  assign req    = SRC_RAISE & mask;
  assign req8   = 8'(req);
  assign ack_oh = 8'd1 << vec_idx;

  logic [2:0] sel_base, sel_idx;
  logic       sel_found;

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
  logic [2:0] last_grant;
  assign sel_base = (last_grant == 3'(NUM_SRC-1)) ? 3'd0 : last_grant + 3'd1;
`else
  assign sel_base = 3'd0;
`endif

  irq_priority_sel #(.NUM_SRC(NUM_SRC)) u_sel (
    .req   (req),
    .base  (sel_base),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // FSM plus the writable registers; the FSM assignments come last so a
  // vector latch overrides a same-cycle VECTOR write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= ST_IDLE;
      mask          <= '0;
      vec_valid     <= 1'b0;
      vec_idx       <= 3'd0;
      CPU_INT_RAISE <= 1'b0;
      SRC_ACK       <= '0;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
      last_grant    <= 3'(NUM_SRC-1);
`endif
    end else begin
      SRC_ACK <= '0;
      if (bus_wr && roff == MASK_OFF) mask      <= NUM_SRC'(BUS_DATA);
      if (bus_wr && roff == VEC_OFF)  vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          CPU_INT_RAISE <= 1'b0;
          if (sel_found) begin
            vec_valid     <= 1'b1;
            vec_idx       <= sel_idx;
            CPU_INT_RAISE <= 1'b1;
            state         <= ST_RAISE;
          end
        end
        ST_RAISE: begin
          // Ack takes precedence over the source withdrawing.
          if (CPU_INT_ACK) begin
            CPU_INT_RAISE <= 1'b0;
            SRC_ACK       <= NUM_SRC'(ack_oh);
            state         <= ST_ACK;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
            last_grant    <= vec_idx;
`endif
          end else if (!req8[vec_idx]) begin
            CPU_INT_RAISE <= 1'b0;
            vec_valid     <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        ST_ACK:   state <= ST_GUARD;
        ST_GUARD: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    vec_rd                = 8'h00;
    vec_rd[VEC_VALID_BIT] = vec_valid;
    vec_rd[2:0]           = vec_idx;
  end

  always_comb begin
    case (roff)
      MASK_OFF:  rd_mux = 8'(mask);
      PEND_OFF:  rd_mux = 8'(SRC_RAISE);
      VEC_OFF:   rd_mux = vec_rd;
      STATE_OFF: rd_mux = {6'b0, state};
      default:   rd_mux = 8'h00;
    endcase
  end

  // Registered read path; BUS_WE also gates the driver so a write that
  // starts mid-cycle never fights the bus master.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      drv_en  <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      drv_en  <= hit && !BUS_WE;
      rd_data <= rd_mux;
    end
  end

  assign BUS_DATA = (drv_en && !BUS_WE) ? rd_data : 8'hzz;

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: a vector table for single-cycle behaviour
// plus hand-written sequences for grant ordering and reset during ACK.
module tb_irq_controller;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET;
  wire  [7:0]   BUS_DATA;
  logic [7:0]   BUS_ADDR;
  logic         BUS_WE;
  logic [N-1:0] SRC_RAISE;
  logic [N-1:0] SRC_ACK;
  logic         CPU_INT_RAISE;
  logic         CPU_INT_ACK;

  logic       tb_oe;
  logic [7:0] tb_drv;
  assign BUS_DATA = tb_oe ? tb_drv : 8'hzz;

  always #5 CLK = ~CLK;

  irq_controller #(.NUM_SRC(N), .BASE_ADDR(8'hE0)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .BUS_DATA      (BUS_DATA),
    .BUS_ADDR      (BUS_ADDR),
    .BUS_WE        (BUS_WE),
    .SRC_RAISE     (SRC_RAISE),
    .SRC_ACK       (SRC_ACK),
    .CPU_INT_RAISE (CPU_INT_RAISE),
    .CPU_INT_ACK   (CPU_INT_ACK)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] src;
    logic       ack;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wd;
    logic       exp_raise;
    logic [3:0] exp_ack;
    logic       chk_rd;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] src, input logic ack, input logic we,
                              input logic [7:0] addr, input logic [7:0] wd,
                              input logic exp_raise, input logic [3:0] exp_ack,
                              input logic chk_rd, input logic [7:0] exp_rd);
    vec_t v;
    v.src = src; v.ack = ack; v.we = we; v.addr = addr; v.wd = wd;
    v.exp_raise = exp_raise; v.exp_ack = exp_ack; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic bus_idle();
    BUS_WE = 1'b0; BUS_ADDR = 8'h00; tb_oe = 1'b0; tb_drv = 8'h00; CPU_INT_ACK = 1'b0;
  endtask

  // Waits for the raise, checks VECTOR, acks, checks the one-cycle SRC_ACK,
  // drops the granted source and runs through GUARD back to IDLE.
  task automatic do_grant(input int idx, input logic rereq);
    logic [3:0] oh;
    bit seen;
    oh   = 4'(1 << idx);
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (CPU_INT_RAISE) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL grant%0d_raise: got timeout expected CPU_INT_RAISE", idx);
    end
    BUS_ADDR = 8'hE2; step();
    chk($sformatf("grant%0d_vector", idx), BUS_DATA, {1'b1, 4'b0, 3'(idx)});
    BUS_ADDR = 8'h00; CPU_INT_ACK = 1'b1; step();
    chk($sformatf("grant%0d_src_ack", idx), 8'(SRC_ACK), 8'(oh));
    chk($sformatf("grant%0d_raise_low", idx), 8'(CPU_INT_RAISE), 8'h00);
    CPU_INT_ACK = 1'b0; SRC_RAISE = SRC_RAISE & ~oh; step();
    chk($sformatf("grant%0d_ack_once", idx), 8'(SRC_ACK), 8'h00);
    step();
    if (rereq) SRC_RAISE = SRC_RAISE | oh;
  endtask

  initial begin
    bus_idle();
    SRC_RAISE = '0;
    RESET = 1'b1;
    step(); step();
    chk("rst_raise", 8'(CPU_INT_RAISE), 8'h00);
    chk("rst_src_ack", 8'(SRC_ACK), 8'h00);
    RESET = 1'b0;

    //             src    ack   we    addr   wd     raise ack    rd    exp_rd
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00)); // MASK after reset
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE2, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00)); // VECTOR after reset
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00)); // STATE after reset
    vq.push_back(mk(4'h0, 1'b0, 1'b1, 8'hE0, 8'h03, 1'b0, 4'h0, 1'b0, 8'h00)); // MASK=03
    vq.push_back(mk(4'h2, 1'b0, 1'b0, 8'hE0, 8'h00, 1'b1, 4'h0, 1'b1, 8'h03)); // raise on src1
    vq.push_back(mk(4'h2, 1'b0, 1'b0, 8'hE2, 8'h00, 1'b1, 4'h0, 1'b1, 8'h81));
    vq.push_back(mk(4'h2, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b1, 4'h0, 1'b1, 8'h01));
    vq.push_back(mk(4'h2, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'h2, 1'b0, 8'h00)); // CPU ack
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h02)); // ACK state
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h03)); // GUARD
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00)); // IDLE
    vq.push_back(mk(4'h0, 1'b0, 1'b1, 8'hE2, 8'hFF, 1'b0, 4'h0, 1'b0, 8'h00)); // write clears valid
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE2, 8'h00, 1'b0, 4'h0, 1'b1, 8'h01));
    vq.push_back(mk(4'h1, 1'b0, 1'b1, 8'hE0, 8'h01, 1'b1, 4'h0, 1'b0, 8'h00)); // raise on src0
    vq.push_back(mk(4'h1, 1'b0, 1'b1, 8'hE0, 8'h00, 1'b1, 4'h0, 1'b0, 8'h00)); // mask it off
    vq.push_back(mk(4'h1, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h01)); // withdraw
    vq.push_back(mk(4'h1, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00));
    vq.push_back(mk(4'h1, 1'b0, 1'b0, 8'hE2, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00)); // valid cleared
    vq.push_back(mk(4'h1, 1'b0, 1'b1, 8'hE0, 8'h01, 1'b0, 4'h0, 1'b0, 8'h00));
    vq.push_back(mk(4'h1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 4'h0, 1'b0, 8'h00));
    vq.push_back(mk(4'h0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 4'h1, 1'b0, 8'h00)); // ack beats withdraw
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h02));
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h03));
    vq.push_back(mk(4'h4, 1'b0, 1'b1, 8'hE1, 8'hFF, 1'b0, 4'h0, 1'b0, 8'h00)); // PENDING write
    vq.push_back(mk(4'h4, 1'b0, 1'b0, 8'hE1, 8'h00, 1'b0, 4'h0, 1'b1, 8'h04));
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE0, 8'h00, 1'b0, 4'h0, 1'b1, 8'h01));
    vq.push_back(mk(4'h0, 1'b0, 1'b1, 8'hE3, 8'hFF, 1'b0, 4'h0, 1'b0, 8'h00)); // STATE write
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE3, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00));
    vq.push_back(mk(4'h1, 1'b0, 1'b1, 8'hE2, 8'hFF, 1'b1, 4'h0, 1'b0, 8'h00)); // latch beats write
    vq.push_back(mk(4'h1, 1'b0, 1'b0, 8'hE2, 8'h00, 1'b1, 4'h0, 1'b1, 8'h80));
    vq.push_back(mk(4'h1, 1'b0, 1'b1, 8'hE0, 8'h00, 1'b1, 4'h0, 1'b0, 8'h00));
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 1'b0, 8'h00));
    vq.push_back(mk(4'h0, 1'b0, 1'b0, 8'hE2, 8'h00, 1'b0, 4'h0, 1'b1, 8'h00));

    foreach (vq[i]) begin
      SRC_RAISE   = vq[i].src;
      CPU_INT_ACK = vq[i].ack;
      BUS_WE      = vq[i].we;
      BUS_ADDR    = vq[i].addr;
      tb_drv      = vq[i].wd;
      tb_oe       = vq[i].we;
      step();
      chk($sformatf("v%0d_raise", i), 8'(CPU_INT_RAISE), 8'(vq[i].exp_raise));
      chk($sformatf("v%0d_src_ack", i), 8'(SRC_ACK), 8'(vq[i].exp_ack));
      if (vq[i].chk_rd) chk($sformatf("v%0d_rd", i), BUS_DATA, vq[i].exp_rd);
    end
    bus_idle();
    SRC_RAISE = '0;

    // Grant ordering with sources 1 and 3 both requesting.
    RESET = 1'b1; step(); RESET = 1'b0;
    BUS_WE = 1'b1; BUS_ADDR = 8'hE0; tb_oe = 1'b1; tb_drv = 8'h0F; step();
    bus_idle();
    SRC_RAISE = 4'b1010;
`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    do_grant(1, 1'b1);
    do_grant(3, 1'b1);
    do_grant(1, 1'b0);
`else
    do_grant(1, 1'b0);
    do_grant(3, 1'b0);
`endif
    SRC_RAISE = '0;
    step(); step();

    // Reset while in ACK.
    RESET = 1'b1; step(); RESET = 1'b0;
    BUS_WE = 1'b1; BUS_ADDR = 8'hE0; tb_oe = 1'b1; tb_drv = 8'h01; SRC_RAISE = 4'b0001; step();
    bus_idle(); step();
    chk("rstack_raise", 8'(CPU_INT_RAISE), 8'h01);
    CPU_INT_ACK = 1'b1; step();
    chk("rstack_in_ack", 8'(SRC_ACK), 8'h01);
    CPU_INT_ACK = 1'b0; RESET = 1'b1; step();
    chk("rstack_src_ack", 8'(SRC_ACK), 8'h00);
    chk("rstack_cpu_raise", 8'(CPU_INT_RAISE), 8'h00);
    RESET = 1'b0; SRC_RAISE = '0; BUS_ADDR = 8'hE0; step();
    chk("rstack_mask", BUS_DATA, 8'h00);
    BUS_ADDR = 8'hE3; step();
    chk("rstack_state", BUS_DATA, 8'h00);
    bus_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
